// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 18;
  localparam int OPC_W       = 4;
  localparam logic [OPC_W-1:0] DEF_HALT_OP = 4'b1111;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter with redirect, sequential increment and wrap at MEM_DEPTH.
module fetch_pc #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 64,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  input  logic              en,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0] target_wrapped;

  // Redirects outside the populated memory fold back into it.
  assign target_wrapped = ADDR_W'(32'(target) % MEM_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (redirect) begin
      pc <= target_wrapped;
    end else if (en) begin
      pc <= (pc == LAST_PC) ? '0 : pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the instruction address and holds a one-entry IR toward decode.
//   state     | meaning
//   RUN       | fetching one word per cycle whenever the IR is free or being accepted
//   HALT_PEND | halt opcode sits in the IR; no new fetches until decode takes it
//   HALTED    | fetch stopped, pc frozen; resume or branch restarts it
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int               ADDR_W    = DEF_ADDR_W,
  parameter int               INSTR_W   = DEF_INSTR_W,
  parameter int               MEM_DEPTH = 64,
  parameter int               RESET_PC  = 0,
  parameter logic [OPC_W-1:0] HALT_OP   = DEF_HALT_OP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  addr_i,
  input  logic [INSTR_W-1:0] instr_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               resume,
  output logic               halted
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [OPC_W-1:0]  opcode;
  logic              accept;
  logic              load;

  assign accept = instr_valid & instr_ready;
  assign load   = (state == RUN) & (~instr_valid | accept);
  assign opcode = instr_rdata[INSTR_W-1 -: OPC_W];
  assign addr_i = pc;

  fetch_pc #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_fetch_pc (
    .clk      (clk),
    .rst      (rst),
    .redirect (branch_valid),
    .target   (branch_target),
    .en       (load),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else if (branch_valid) begin
      // Redirect wins everywhere and drops the IR even if decode took it.
      state       <= RUN;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (load) begin
      instr       <= instr_rdata;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      if (opcode == HALT_OP) begin
        state <= HALT_PEND;
      end
    end else if (accept) begin
      instr_valid <= 1'b0;
      if (state == HALT_PEND) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end else if (state == HALTED && resume) begin
      state  <= RUN;
      halted <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr_i;
  logic [17:0] instr_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [17:0] instr;
  logic [7:0]  instr_pc;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        resume;
  logic        halted;

  logic [17:0] mem [64];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [17:0] w;
    int          pc;
  } ir_t;

  // Model: next fetch address, IR as a 0/1-entry queue, halt flags.
  int  m_pc;
  ir_t m_ir[$];
  bit  m_pend;
  bit  m_stopped;

  always #5 clk = ~clk;

  assign instr_rdata = mem[addr_i[5:0]];

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .addr_i        (addr_i),
    .instr_rdata   (instr_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .resume        (resume),
    .halted        (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_ir.delete();
    m_pend = 0;
    m_stopped = 0;
  endtask

  task automatic model_edge(input logic br, input logic [7:0] tgt, input logic rdy, input logic res);
    bit  acc;
    ir_t e;
    acc = (m_ir.size() > 0) && rdy;
    if (br) begin
      m_ir.delete();
      m_pc = int'(tgt) % 64;
      m_pend = 0;
      m_stopped = 0;
    end else if (!m_pend && !m_stopped && (m_ir.size() == 0 || acc)) begin
      e.w  = mem[m_pc];
      e.pc = m_pc;
      m_ir.delete();
      m_ir.push_back(e);
      m_pc = (m_pc + 1) % 64;
      if (e.w[17:14] == 4'hF) m_pend = 1;
    end else if (acc) begin
      m_ir.delete();
      if (m_pend) begin
        m_pend = 0;
        m_stopped = 1;
      end
    end else if (m_stopped && res) begin
      m_stopped = 0;
    end
  endtask

  task automatic check_all();
    check("valid", 32'(instr_valid), 32'(m_ir.size() > 0));
    check("addr_i", 32'(addr_i), 32'(m_pc));
    check("halted", 32'(halted), 32'(m_stopped));
    if (m_ir.size() > 0) begin
      check("instr", 32'(instr), 32'(m_ir[0].w));
      check("instr_pc", 32'(instr_pc), 32'(m_ir[0].pc));
    end
  endtask

  task automatic step(input logic br, input logic [7:0] tgt, input logic rdy, input logic res);
    branch_valid  = br;
    branch_target = tgt;
    instr_ready   = rdy;
    resume        = res;
    model_edge(br, tgt, rdy, res);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [17:0] w;
    rst = 1'b1;
    branch_valid = 1'b0;
    branch_target = '0;
    instr_ready = 1'b0;
    resume = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = 18'($urandom);
      if (w[17:14] == 4'hF) w[17] = 1'b0;
      mem[i] = w;
    end
    w = 18'($urandom);
    mem[5] = {4'hF, w[13:0]};
    model_reset();

    #2;
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    check("rst_addr", 32'(addr_i), 0);
    check("rst_halted", 32'(halted), 0);
    #10 rst = 1'b0;

    // Sequential stream, then a 3-cycle stall on B.
    step(0, 0, 1, 0);
    check("first_valid", 32'(instr_valid), 1);
    check("first_word", 32'(instr), 32'(mem[0]));
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check("stall_instr", 32'(instr), 32'(mem[1]));
      check("stall_pc", 32'(addr_i), 2);
    end
    step(0, 0, 1, 0);
    check("after_stall", 32'(instr_pc), 2);

    // Branch while C is accepted: one bubble, then target word.
    step(1, 8'h20, 1, 0);
    check("flush_valid", 32'(instr_valid), 0);
    step(0, 0, 1, 0);
    check("br_instr_pc", 32'(instr_pc), 32'h20);

    // Out-of-range target folds to 5, where the halt word sits.
    step(1, 8'h45, 1, 0);
    check("br_wrap", 32'(addr_i), 5);
    step(0, 0, 1, 0);
    check("halt_word", 32'(instr), 32'(mem[5]));
    step(0, 0, 1, 0);
    check("halted_set", 32'(halted), 1);
    check("halted_novalid", 32'(instr_valid), 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("halted_pc_hold", 32'(addr_i), 6);
    step(0, 0, 1, 1);
    check("resume_clear", 32'(halted), 0);
    step(0, 0, 1, 0);
    check("resume_word6", 32'(instr_pc), 6);

    // Wrap of sequential fetch at the top of memory.
    step(1, 8'd62, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("pc63", 32'(instr_pc), 63);
    step(0, 0, 1, 0);
    check("wrap_pc0", 32'(instr_pc), 0);
    check("wrap_no_gap", 32'(instr_valid), 1);

    // Randomized traffic with scattered halt words.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 7) == 0) mem[i][17:14] = 4'hF;
    end
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset in the middle of a stall with a valid IR.
    step(1, 8'd10, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("prerst_valid", 32'(instr_valid), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_valid", 32'(instr_valid), 0);
    check("async_pc", 32'(addr_i), 0);
    check("async_halted", 32'(halted), 0);
    check("async_instr", 32'(instr), 0);
    #3 rst = 1'b0;
    step(0, 0, 1, 0);
    check("post_rst_word", 32'(instr_pc), 0);
    step(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
